// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types for the ID/EX hazard scoreboard: writeback select, stall causes,
// and the cause-priority encoder.
package hazard_scoreboard_unit_pkg;

  localparam int unsigned CORE_REG_ADDR_WIDTH = 5;
  localparam int unsigned MAX_LOAD_LAT        = 4;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC,
    WB_CSR
  } wb_sel_e;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_MDU_RAW,
    HZ_MDU_BUSY
  } hz_cause_e;

  // Load-use outranks MDU RAW, which outranks MDU structural busy.
  function automatic hz_cause_e cause_prio(input logic load_use, input logic mdu_raw,
                                           input logic mdu_busy);
    hz_cause_e c;
    if (load_use)      c = HZ_LOAD_USE;
    else if (mdu_raw)  c = HZ_MDU_RAW;
    else if (mdu_busy) c = HZ_MDU_BUSY;
    else               c = HZ_NONE;
    return c;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage view of the hazard scoreboard: instruction fields in, stall info out.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
);
  import hazard_scoreboard_unit_pkg::*;

  logic                      id_valid_i;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i;
  logic                      rs1_used_ID_i;
  logic                      rs2_used_ID_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_ID_i;
  logic                      reg_write_ID_i;
  wb_sel_e                   WBSel_ID_i;
  logic                      is_mdu_ID_i;
  logic                      flush_i;
  logic                      mdu_done_i;
  logic                      cnt_clr_i;
  logic                      stall_o;
  hz_cause_e                 stall_cause_o;
  logic [CNT_WIDTH-1:0]      stall_cnt_o;

  // Driven by the pipeline control side.
  modport master (
    output id_valid_i, rs1_addr_ID_i, rs2_addr_ID_i, rs1_used_ID_i, rs2_used_ID_i,
           rd_addr_ID_i, reg_write_ID_i, WBSel_ID_i, is_mdu_ID_i, flush_i, mdu_done_i,
           cnt_clr_i,
    input  stall_o, stall_cause_o, stall_cnt_o
  );

  // The scoreboard itself.
  modport slave (
    input  id_valid_i, rs1_addr_ID_i, rs2_addr_ID_i, rs1_used_ID_i, rs2_used_ID_i,
           rd_addr_ID_i, reg_write_ID_i, WBSel_ID_i, is_mdu_ID_i, flush_i, mdu_done_i,
           cnt_clr_i,
    output stall_o, stall_cause_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_scoreboard_unit_load_shadow_pipe.sv
// Shadow pipeline of in-flight loads ({valid, rd} per stage) with per-source match.
module hz_load_shadow_pipe #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned LOAD_LAT       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] push_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic                      rs1_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                      rs2_en_i,
  output logic                      rs1_hit_o,
  output logic                      rs2_hit_o
);

  logic [LOAD_LAT-1:0]       valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [LOAD_LAT];
  logic [REG_ADDR_WIDTH-1:0] rd_d [LOAD_LAT];

  // Shift every cycle; stage 0 takes the newly issued load (or a bubble).
  always_comb begin
    valid_d[0] = push_valid_i;
    rd_d[0]    = push_rd_i;
    for (int k = 1; k < int'(LOAD_LAT); k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
  end

  // Stage registers; reset discards all in-flight loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < int'(LOAD_LAT); k++) rd_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < int'(LOAD_LAT); k++) rd_q[k] <= rd_d[k];
    end
  end

  // A source hits if any valid stage still owes it data.
  always_comb begin
    rs1_hit_o = 1'b0;
    rs2_hit_o = 1'b0;
    for (int k = 0; k < int'(LOAD_LAT); k++) begin
      if (valid_q[k] && rs1_en_i && (rd_q[k] == rs1_addr_i)) rs1_hit_o = 1'b1;
      if (valid_q[k] && rs2_en_i && (rd_q[k] == rs2_addr_i)) rs2_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID/EX hazard scoreboard: load-use, MDU RAW and MDU structural stalls, plus a
// saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hazard_scoreboard_unit_if.slave hz_io
);

  logic                      src1_en, src2_en;
  logic                      ld_hit1, ld_hit2;
  logic                      gate, mdu_live;
  logic                      load_use, mdu_raw, mdu_bsy, stall;
  logic                      issue, push_valid;
  logic                      mdu_busy_q, mdu_busy_d;
  logic [REG_ADDR_WIDTH-1:0] mdu_rd_q, mdu_rd_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  hz_load_shadow_pipe #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .LOAD_LAT      (LOAD_LAT)
  ) u_load_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(push_valid),
    .push_rd_i   (hz_io.rd_addr_ID_i),
    .rs1_addr_i  (hz_io.rs1_addr_ID_i),
    .rs1_en_i    (src1_en),
    .rs2_addr_i  (hz_io.rs2_addr_ID_i),
    .rs2_en_i    (src2_en),
    .rs1_hit_o   (ld_hit1),
    .rs2_hit_o   (ld_hit2)
  );

  // Stall decode; x0 sources never match, flush and reset mask everything.
  always_comb begin
    src1_en  = hz_io.rs1_used_ID_i & (hz_io.rs1_addr_ID_i != '0);
    src2_en  = hz_io.rs2_used_ID_i & (hz_io.rs2_addr_ID_i != '0);
    gate     = hz_io.id_valid_i & ~hz_io.flush_i & ~rst_i;
    // A done MDU result is forwardable this cycle, so it no longer blocks.
    mdu_live = mdu_busy_q & ~hz_io.mdu_done_i;
    load_use = gate & (ld_hit1 | ld_hit2);
    mdu_raw  = gate & mdu_live & (mdu_rd_q != '0) &
               ((src1_en & (hz_io.rs1_addr_ID_i == mdu_rd_q)) |
                (src2_en & (hz_io.rs2_addr_ID_i == mdu_rd_q)));
    mdu_bsy  = gate & hz_io.is_mdu_ID_i & mdu_live;
    stall    = load_use | mdu_raw | mdu_bsy;
    issue    = hz_io.id_valid_i & ~stall & ~hz_io.flush_i;
    push_valid = issue & hz_io.reg_write_ID_i & (hz_io.WBSel_ID_i == WB_MEM) &
                 (hz_io.rd_addr_ID_i != '0);
  end

  // MDU tracker next state; a new MDU issue beats a coincident done.
  always_comb begin
    mdu_busy_d = mdu_busy_q;
    mdu_rd_d   = mdu_rd_q;
    if (issue && hz_io.is_mdu_ID_i) begin
      mdu_busy_d = 1'b1;
      mdu_rd_d   = hz_io.reg_write_ID_i ? hz_io.rd_addr_ID_i : '0;
    end else if (hz_io.mdu_done_i) begin
      mdu_busy_d = 1'b0;
    end
  end

  // Stall counter next state: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (hz_io.cnt_clr_i) begin
      cnt_d = '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdu_busy_q <= 1'b0;
      mdu_rd_q   <= '0;
      cnt_q      <= '0;
    end else begin
      mdu_busy_q <= mdu_busy_d;
      mdu_rd_q   <= mdu_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign hz_io.stall_o       = stall;
  assign hz_io.stall_cause_o = cause_prio(load_use, mdu_raw, mdu_bsy);
  assign hz_io.stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench: two scoreboards (LOAD_LAT=1 with a 4-bit counter, LOAD_LAT=3 with a
// 32-bit counter) share one stimulus stream and are checked against a
// distance-based reference model every cycle, plus directed scenario checks.
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, rs1_used, rs2_used, reg_write, is_mdu, flush, mdu_done, cnt_clr;
  logic [4:0] rs1, rs2, rd;
  wb_sel_e    wbsel;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  ifc1 ();
  hazard_scoreboard_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) ifc3 ();

  assign ifc1.id_valid_i = id_valid;     assign ifc3.id_valid_i = id_valid;
  assign ifc1.rs1_addr_ID_i = rs1;       assign ifc3.rs1_addr_ID_i = rs1;
  assign ifc1.rs2_addr_ID_i = rs2;       assign ifc3.rs2_addr_ID_i = rs2;
  assign ifc1.rs1_used_ID_i = rs1_used;  assign ifc3.rs1_used_ID_i = rs1_used;
  assign ifc1.rs2_used_ID_i = rs2_used;  assign ifc3.rs2_used_ID_i = rs2_used;
  assign ifc1.rd_addr_ID_i = rd;         assign ifc3.rd_addr_ID_i = rd;
  assign ifc1.reg_write_ID_i = reg_write; assign ifc3.reg_write_ID_i = reg_write;
  assign ifc1.WBSel_ID_i = wbsel;        assign ifc3.WBSel_ID_i = wbsel;
  assign ifc1.is_mdu_ID_i = is_mdu;      assign ifc3.is_mdu_ID_i = is_mdu;
  assign ifc1.flush_i = flush;           assign ifc3.flush_i = flush;
  assign ifc1.mdu_done_i = mdu_done;     assign ifc3.mdu_done_i = mdu_done;
  assign ifc1.cnt_clr_i = cnt_clr;       assign ifc3.cnt_clr_i = cnt_clr;

  hazard_scoreboard_unit #(.REG_ADDR_WIDTH(5), .LOAD_LAT(1), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .hz_io(ifc1)
  );
  hazard_scoreboard_unit #(.REG_ADDR_WIDTH(5), .LOAD_LAT(3), .CNT_WIDTH(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .hz_io(ifc3)
  );

  always #5 clk = ~clk;

  // Reference model: the cycle each register was last loaded, MDU owner, counter.
  longint cyc;
  longint last_ld [2][32];
  bit     mbusy [2];
  int     mrd [2];
  longint mcnt [2];
  longint cmax [2] = '{15, 64'hFFFF_FFFF};
  int     lat [2] = '{1, 3};
  bit     obs_st [2];
  int     obs_cs [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) last_ld[k][r] = -100;
      mbusy[k] = 0;
      mrd[k]   = 0;
      mcnt[k]  = 0;
    end
  endfunction

  // A load is still unforwardable while its distance is within 1..LOAD_LAT.
  function automatic bit in_win(input int k, input logic [4:0] r);
    longint d;
    d = cyc - last_ld[k][r];
    return (d >= 1) && (d <= lat[k]);
  endfunction

  function automatic void model_eval(input int k, output bit st, output int cs);
    bit h1, h2, lu, raw, bz;
    h1  = rs1_used && (rs1 != 0);
    h2  = rs2_used && (rs2 != 0);
    lu  = (h1 && in_win(k, rs1)) || (h2 && in_win(k, rs2));
    raw = mbusy[k] && !mdu_done && (mrd[k] != 0) &&
          ((h1 && int'(rs1) == mrd[k]) || (h2 && int'(rs2) == mrd[k]));
    bz  = is_mdu && mbusy[k] && !mdu_done;
    if (!id_valid || flush || rst) begin
      lu = 0; raw = 0; bz = 0;
    end
    st = lu | raw | bz;
    cs = lu ? 1 : (raw ? 2 : (bz ? 3 : 0));
  endfunction

  function automatic void model_update(input int k, input bit st);
    bit iss;
    iss = id_valid && !st && !flush;
    if (iss && reg_write && wbsel == WB_MEM && rd != 0) last_ld[k][rd] = cyc;
    if (iss && is_mdu) begin
      mbusy[k] = 1;
      mrd[k]   = reg_write ? int'(rd) : 0;
    end else if (mdu_done) begin
      mbusy[k] = 0;
    end
    if (cnt_clr) mcnt[k] = 0;
    else if (st && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
  endfunction

  // One clock: compare both DUTs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit st [2];
    int cs [2];
    #2;
    for (int k = 0; k < 2; k++) model_eval(k, st[k], cs[k]);
    obs_st[0] = ifc1.stall_o;  obs_cs[0] = int'(ifc1.stall_cause_o);
    obs_st[1] = ifc3.stall_o;  obs_cs[1] = int'(ifc3.stall_cause_o);
    chk("lat1_stall", 64'(ifc1.stall_o), 64'(st[0]));
    chk("lat1_cause", 64'(ifc1.stall_cause_o), 64'(cs[0]));
    chk("lat1_cnt", 64'(ifc1.stall_cnt_o), 64'(mcnt[0]));
    chk("lat3_stall", 64'(ifc3.stall_o), 64'(st[1]));
    chk("lat3_cause", 64'(ifc3.stall_cause_o), 64'(cs[1]));
    chk("lat3_cnt", 64'(ifc3.stall_cnt_o), 64'(mcnt[1]));
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_update(k, st[k]);
    cyc++;
    #1;
  endtask

  task automatic set_i(input bit v, input logic [4:0] a1, input bit u1, input logic [4:0] a2,
                       input bit u2, input logic [4:0] d, input bit w, input wb_sel_e ws,
                       input bit m);
    id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; reg_write = w; wbsel = ws; is_mdu = m;
  endtask

  task automatic ld(input logic [4:0] d);
    set_i(1, 0, 1, 0, 0, d, 1, WB_MEM, 0);
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2);
    set_i(1, a1, 1, a2, 1, d, 1, WB_ALU, 0);
  endtask

  task automatic idle();
    set_i(0, 0, 0, 0, 0, 0, 0, WB_ALU, 0);
  endtask

  // Present the current instruction until DUT k lets it issue; return stall cycles.
  task automatic run(input int k, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 24 && !done; i++) begin
      tick();
      if (obs_st[k] === 1'b1) n++;
      else done = 1;
    end
    chk("run_issued", 64'(done), 64'd1);
  endtask

  task automatic drain();
    idle();
    mdu_done = 1;
    tick();
    mdu_done = 0;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    cyc = 0;
    rst = 1; flush = 0; mdu_done = 0; cnt_clr = 0;
    idle();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    tick();  // reset-state checks while rst is still high
    rst = 0;
    tick();
    chk("reset_cnt1", 64'(ifc1.stall_cnt_o), 64'd0);

    // Classic single-cycle load-use, then the same with rs1 not read.
    cnt_clr = 1; idle(); tick(); cnt_clr = 0;
    ld(5); run(0, n);
    alu(6, 5, 0); rs2_used = 0; run(0, n);
    chk("p1_stall_cycles", 64'(n), 64'd1);
    chk("p1_cnt", 64'(ifc1.stall_cnt_o), 64'd1);
    drain();
    ld(5); run(0, n);
    alu(6, 5, 0); rs1_used = 0; rs2_used = 0; run(0, n);
    chk("p1_unused_src", 64'(n), 64'd0);
    drain();

    // Three-cycle load latency at distances 1, 2 and 4.
    ld(7); run(1, n); alu(8, 7, 0); run(1, n);
    chk("p2_dist1", 64'(n), 64'd3);
    drain();
    ld(7); run(1, n); alu(20, 1, 2); run(1, n); alu(8, 0, 7); run(1, n);
    chk("p2_dist2", 64'(n), 64'd2);
    drain();
    ld(7); run(1, n);
    repeat (3) begin alu(20, 1, 2); run(1, n); end
    alu(8, 7, 7); run(1, n);
    chk("p2_dist4", 64'(n), 64'd0);
    drain();

    // Dependent add waits on a six-cycle divide and issues on done.
    set_i(1, 2, 1, 3, 1, 9, 1, WB_ALU, 1); run(1, n);
    alu(10, 9, 0);
    n = 0;
    repeat (6) begin tick(); if (obs_st[1] === 1'b1) n++; end
    chk("p3_raw_cycles", 64'(n), 64'd6);
    chk("p3_cause", 64'(obs_cs[1]), 64'(HZ_MDU_RAW));
    mdu_done = 1; tick(); mdu_done = 0;
    chk("p3_issue_on_done", 64'(obs_st[1]), 64'd0);
    drain();

    // Structural MDU busy, then done coinciding with the next MDU op.
    set_i(1, 2, 1, 3, 1, 9, 1, WB_ALU, 1); run(1, n);
    set_i(1, 4, 1, 5, 1, 10, 1, WB_ALU, 1); tick();
    chk("p4_busy_cause", 64'(obs_cs[1]), 64'(HZ_MDU_BUSY));
    mdu_done = 1; tick(); mdu_done = 0;
    chk("p4_done_issue", 64'(obs_st[1]), 64'd0);
    alu(11, 10, 0); tick();
    chk("p4_new_rd_raw", 64'(obs_cs[1]), 64'(HZ_MDU_RAW));
    mdu_done = 1; tick(); mdu_done = 0;
    drain();

    // x0 is never tracked; flush masks the consumer's stall.
    ld(0); run(1, n); alu(12, 0, 0); run(1, n);
    chk("p5_x0", 64'(n), 64'd0);
    ld(3); run(1, n); alu(12, 3, 0); flush = 1; tick();
    chk("p5_flush1", 64'(obs_st[0]), 64'd0);
    chk("p5_flush3", 64'(obs_st[1]), 64'd0);
    flush = 0;
    drain();

    // Counter saturation, clear during stall, reset in the middle of an MDU op.
    set_i(1, 2, 1, 3, 1, 9, 1, WB_ALU, 1); run(1, n);
    alu(13, 9, 0);
    repeat (20) tick();
    chk("p6_saturate", 64'(ifc1.stall_cnt_o), 64'd15);
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("p6_clr_during_stall", 64'(obs_st[1]), 64'd1);
    chk("p6_clr_cnt1", 64'(ifc1.stall_cnt_o), 64'd0);
    chk("p6_clr_cnt3", 64'(ifc3.stall_cnt_o), 64'd0);
    rst = 1; tick(); rst = 0;
    tick();
    chk("p6_rst_clears_mdu1", 64'(obs_st[0]), 64'd0);
    chk("p6_rst_clears_mdu3", 64'(obs_st[1]), 64'd0);
    drain();

    // Random traffic over a small register window to force frequent matches.
    for (int i = 0; i < 800; i++) begin
      id_valid  = ($urandom_range(0, 7) != 0);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      rs1_used  = $urandom_range(0, 1);
      rs2_used  = $urandom_range(0, 1);
      rd        = 5'($urandom_range(0, 7));
      reg_write = ($urandom_range(0, 3) != 0);
      wbsel     = ($urandom_range(0, 1) == 0) ? WB_MEM : wb_sel_e'($urandom_range(0, 3));
      is_mdu    = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      mdu_done  = ($urandom_range(0, 3) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0; flush = 0; mdu_done = 0; cnt_clr = 0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
